tl_inflight_tracker: RTL and testbench

- Parametrised TileLink A/D/E transaction tracker for the cache's client port; monitors handshakes only and drives no valid/ready.
- Per-channel beat counting derived from size and data-beat width, with first/last flags.
- One outstanding-request record per source ID, plus a count of GrantAcks still owed on E.
- Flags protocol violations: duplicate source, response to an idle source, wrong response opcode, spurious GrantAck.

---
 rtl/tl_inflight_tracker_pkg.sv | 64 ++++++
 rtl/tl_inflight_tracker_if.sv | 53 +++++
 rtl/tl_beat_counter.sv | 47 ++++
 rtl/tl_inflight_tracker.sv | 123 ++++++++++++
 tb/tb_tl_inflight_tracker.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_inflight_tracker_pkg.sv
// -----------------------------------------------------------------------------
// Packages for the TileLink in-flight tracker.
//   TLMessages  : A and D channel opcode constants.
//   BundleParam : beat-count helper, opcode predicates, error codes.
// No ports; imported by the tracker, its beat counter and the testbench.
// -----------------------------------------------------------------------------
package TLMessages;
  // A channel opcodes
  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] ArithmeticData = 3'd2;
  localparam logic [2:0] LogicalData    = 3'd3;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] Hint           = 3'd5;
  localparam logic [2:0] AcquireBlock   = 3'd6;
  localparam logic [2:0] AcquirePerm    = 3'd7;
  // D channel opcodes
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;
  localparam logic [2:0] HintAck        = 3'd2;
  localparam logic [2:0] Grant          = 3'd4;
  localparam logic [2:0] GrantData      = 3'd5;
  localparam logic [2:0] ReleaseAck     = 3'd6;
endpackage

package BundleParam;
  import TLMessages::*;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_A_DUP       = 3'd1;
  localparam logic [2:0] ERR_D_IDLE      = 3'd2;
  localparam logic [2:0] ERR_D_MISMATCH  = 3'd3;
  localparam logic [2:0] ERR_E_UNDERFLOW = 3'd4;

  // Number of beats a message of 2^size bytes occupies on a bus carrying
  // 2^lg_beat_bytes bytes per beat. Sub-beat messages still take one beat.
  function automatic int unsigned beats(input int unsigned size,
                                        input int unsigned lg_beat_bytes);
    if (size <= lg_beat_bytes) return 32'd1;
    return 32'd1 << (size - lg_beat_bytes);
  endfunction

  // A messages that carry a data payload (PutFull, PutPartial, Arithmetic, Logical).
  function automatic logic a_has_data(input logic [2:0] op);
    return (op <= LogicalData);
  endfunction

  // D messages that carry a data payload.
  function automatic logic d_has_data(input logic [2:0] op);
    return (op == AccessAckData) || (op == GrantData);
  endfunction

  // Is d_op a legal answer to a request that was issued with req_op?
  function automatic logic d_opcode_ok(input logic [2:0] req_op, input logic [2:0] d_op);
    logic ok;
    case (req_op)
      PutFullData, PutPartialData:     ok = (d_op == AccessAck);
      ArithmeticData, LogicalData, Get: ok = (d_op == AccessAckData);
      Hint:                            ok = (d_op == HintAck);
      default:                         ok = (d_op == Grant) || (d_op == GrantData);
    endcase
    return ok;
  endfunction
endpackage

// File: rtl/tl_inflight_tracker_if.sv
// -----------------------------------------------------------------------------
// Bundle between the cache client port and the in-flight tracker.
//   Handshake inputs : a_*, d_*, e_valid/e_ready (observed only).
//   Status outputs   : a_first/a_last, d_first/d_last, src_busy, inflight,
//                      e_pending, err_valid, err_code.
// Handshake rule for every channel: a beat transfers on a clock edge where
// valid and ready are both high (fire = valid & ready); payload fields are
// only meaningful while valid is high. The tracker never drives valid/ready.
// master : the side that drives the channels (client/bench).
// slave  : the tracker, which observes and reports.
// -----------------------------------------------------------------------------
interface tl_inflight_tracker_if #(
  parameter int SOURCE_BITS = 3,
  parameter int SIZE_BITS   = 4
);
  logic                          a_valid;
  logic                          a_ready;
  logic [2:0]                    a_opcode;
  logic [SIZE_BITS-1:0]          a_size;
  logic [SOURCE_BITS-1:0]        a_source;
  logic                          d_valid;
  logic                          d_ready;
  logic [2:0]                    d_opcode;
  logic [SIZE_BITS-1:0]          d_size;
  logic [SOURCE_BITS-1:0]        d_source;
  logic                          e_valid;
  logic                          e_ready;
  logic                          a_first;
  logic                          a_last;
  logic                          d_first;
  logic                          d_last;
  logic                          src_busy;
  logic [(1<<SOURCE_BITS)-1:0]   inflight;
  logic [SOURCE_BITS:0]          e_pending;
  logic                          err_valid;
  logic [2:0]                    err_code;

  modport master (
    output a_valid, a_ready, a_opcode, a_size, a_source,
    output d_valid, d_ready, d_opcode, d_size, d_source,
    output e_valid, e_ready,
    input  a_first, a_last, d_first, d_last, src_busy,
    input  inflight, e_pending, err_valid, err_code
  );

  modport slave (
    input  a_valid, a_ready, a_opcode, a_size, a_source,
    input  d_valid, d_ready, d_opcode, d_size, d_source,
    input  e_valid, e_ready,
    output a_first, a_last, d_first, d_last, src_busy,
    output inflight, e_pending, err_valid, err_code
  );
endinterface

// File: rtl/tl_beat_counter.sv
// -----------------------------------------------------------------------------
// Per-channel beat counter. Holds the number of beats still to come in the
// current message (0 = between messages).
//   clock, reset : clock, async active-high reset
//   i_fire       : a beat transferred this cycle
//   i_has_data   : current message carries data (multi-beat capable)
//   i_size       : log2 bytes; only looked at on the first beat
//   o_first      : current beat is the first of its message (combinational)
//   o_last       : current beat is the last of its message (combinational)
// -----------------------------------------------------------------------------
module tl_beat_counter
  import BundleParam::*;
#(
  parameter int SIZE_BITS = 4,
  parameter int DATA_BITS = 128
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_fire,
  input  logic                 i_has_data,
  input  logic [SIZE_BITS-1:0] i_size,
  output logic                 o_first,
  output logic                 o_last
);
  localparam int unsigned LG_BEAT  = $clog2(DATA_BITS / 8);
  // Largest message has 2^(2^SIZE_BITS - 1 - LG_BEAT) beats, which fits here.
  localparam int          CNT_BITS = 1 << SIZE_BITS;

  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_beats;

  always_comb begin
    w_beats = CNT_BITS'(1);
    if (i_has_data) w_beats = CNT_BITS'(beats(32'(i_size), LG_BEAT));
    o_first = (r_cnt == '0);
    // Later beats ignore i_size: the remaining count alone decides last.
    o_last  = o_first ? (w_beats == CNT_BITS'(1)) : (r_cnt == CNT_BITS'(1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_fire) begin
      r_cnt <= o_first ? (w_beats - CNT_BITS'(1)) : (r_cnt - CNT_BITS'(1));
    end
  end
endmodule

// File: rtl/tl_inflight_tracker.sv
// -----------------------------------------------------------------------------
// TileLink A/D/E in-flight tracker for the cache client port. Observes the
// handshakes, keeps one request record per source, counts GrantAcks owed on
// E and reports protocol violations as a registered one-cycle pulse.
//   clock, reset : clock, async active-high reset
//   tl (slave)   : A/D/E handshake inputs; first/last flags, src_busy,
//                  inflight vector, e_pending, err_valid/err_code outputs
// err_code: 1 A-dup, 2 D-idle, 3 D-mismatch, 4 E-underflow (lowest wins).
// -----------------------------------------------------------------------------
module tl_inflight_tracker
  import TLMessages::*;
  import BundleParam::*;
#(
  parameter int SOURCE_BITS = 3,
  parameter int SIZE_BITS   = 4,
  parameter int DATA_BITS   = 128
) (
  input logic                  clock,
  input logic                  reset,
  tl_inflight_tracker_if.slave tl
);
  localparam int NSRC    = 1 << SOURCE_BITS;
  localparam int EP_BITS = SOURCE_BITS + 1;

  logic [NSRC-1:0]    r_inflight;
  logic [2:0]         r_req_op [NSRC];
  logic [EP_BITS-1:0] r_e_pending;
  logic               r_err_valid;
  logic [2:0]         r_err_code;

  logic w_a_fire, w_d_fire, w_e_fire;
  logic w_a_first, w_a_last, w_d_first, w_d_last;
  logic w_a_set, w_d_tracked, w_d_check, w_d_clr, w_grant;
  logic w_err_a_dup, w_err_d_idle, w_err_d_mis, w_err_e_under;
  logic [NSRC-1:0]    w_inflight_nxt;
  logic [EP_BITS-1:0] w_e_pending_nxt;
  logic [2:0]         w_err_code;

  tl_beat_counter #(.SIZE_BITS(SIZE_BITS), .DATA_BITS(DATA_BITS)) u_a_cnt (
    .clock      (clock),
    .reset      (reset),
    .i_fire     (w_a_fire),
    .i_has_data (a_has_data(tl.a_opcode)),
    .i_size     (tl.a_size),
    .o_first    (w_a_first),
    .o_last     (w_a_last)
  );

  tl_beat_counter #(.SIZE_BITS(SIZE_BITS), .DATA_BITS(DATA_BITS)) u_d_cnt (
    .clock      (clock),
    .reset      (reset),
    .i_fire     (w_d_fire),
    .i_has_data (d_has_data(tl.d_opcode)),
    .i_size     (tl.d_size),
    .o_first    (w_d_first),
    .o_last     (w_d_last)
  );

  always_comb begin
    w_a_fire    = tl.a_valid & tl.a_ready;
    w_d_fire    = tl.d_valid & tl.d_ready;
    w_e_fire    = tl.e_valid & tl.e_ready;
    w_a_set     = w_a_fire & w_a_first;
    // ReleaseAck answers C-channel traffic, so it never touches A records.
    w_d_tracked = (tl.d_opcode != ReleaseAck);
    w_d_check   = w_d_fire & w_d_first & w_d_tracked;
    w_d_clr     = w_d_fire & w_d_last & w_d_tracked;
    w_grant     = w_d_clr & ((tl.d_opcode == Grant) || (tl.d_opcode == GrantData));

    // A same-cycle D last beat to the same source frees it before the new
    // request claims it, so that overlap is legal.
    w_err_a_dup   = w_a_set & r_inflight[tl.a_source] &
                    ~(w_d_clr & (tl.d_source == tl.a_source));
    w_err_d_idle  = w_d_check & ~r_inflight[tl.d_source];
    w_err_d_mis   = w_d_check & r_inflight[tl.d_source] &
                    ~d_opcode_ok(r_req_op[tl.d_source], tl.d_opcode);
    w_err_e_under = w_e_fire & (r_e_pending == '0);

    w_err_code = ERR_NONE;
    if      (w_err_a_dup)   w_err_code = ERR_A_DUP;
    else if (w_err_d_idle)  w_err_code = ERR_D_IDLE;
    else if (w_err_d_mis)   w_err_code = ERR_D_MISMATCH;
    else if (w_err_e_under) w_err_code = ERR_E_UNDERFLOW;

    // Clear before set: order matters when both hit the same source.
    w_inflight_nxt = r_inflight;
    if (w_d_clr) w_inflight_nxt[tl.d_source] = 1'b0;
    if (w_a_set) w_inflight_nxt[tl.a_source] = 1'b1;

    // Grant and GrantAck in the same cycle cancel; underflow saturates at 0.
    w_e_pending_nxt = r_e_pending;
    if (w_grant && !w_e_fire)
      w_e_pending_nxt = r_e_pending + EP_BITS'(1);
    else if (w_e_fire && !w_grant && (r_e_pending != '0))
      w_e_pending_nxt = r_e_pending - EP_BITS'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_inflight  <= '0;
      r_e_pending <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      for (int i = 0; i < NSRC; i++) r_req_op[i] <= 3'd0;
    end else begin
      r_inflight  <= w_inflight_nxt;
      r_e_pending <= w_e_pending_nxt;
      r_err_valid <= (w_err_code != ERR_NONE);
      r_err_code  <= w_err_code;
      if (w_a_set) r_req_op[tl.a_source] <= tl.a_opcode;
    end
  end

  assign tl.a_first   = w_a_first;
  assign tl.a_last    = w_a_last;
  assign tl.d_first   = w_d_first;
  assign tl.d_last    = w_d_last;
  assign tl.src_busy  = r_inflight[tl.a_source];
  assign tl.inflight  = r_inflight;
  assign tl.e_pending = r_e_pending;
  assign tl.err_valid = r_err_valid;
  assign tl.err_code  = r_err_code;
endmodule

// File: tb/tb_tl_inflight_tracker.sv
// -----------------------------------------------------------------------------
// Testbench for tl_inflight_tracker (SOURCE_BITS=3, SIZE_BITS=4, DATA_BITS=128).
// Directed vector table, a mid-burst reset sequence, then random traffic
// checked against a behavioural model built from integer counters and arrays.
// -----------------------------------------------------------------------------
module tb_tl_inflight_tracker;
  import TLMessages::*;

  typedef struct {
    logic       av;
    logic [2:0] aop;
    logic [3:0] asz;
    logic [2:0] asrc;
    logic       dv;
    logic [2:0] dop;
    logic [3:0] dsz;
    logic [2:0] dsrc;
    logic       ev;
    logic [3:0] fl;    // {a_first, a_last, d_first, d_last} during the cycle
    logic [7:0] infl;  // inflight after the edge
    int         ep;    // e_pending after the edge
    int         err;   // err_code after the edge
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [7:0]  mdl_infl = '0;
  logic [15:0] exp_q[$];
  vec_t        vecs[$];

  tl_inflight_tracker_if #(.SOURCE_BITS(3), .SIZE_BITS(4)) tl ();

  tl_inflight_tracker #(.SOURCE_BITS(3), .SIZE_BITS(4), .DATA_BITS(128)) dut (
    .clock (clock),
    .reset (reset),
    .tl    (tl)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [2:0] aop, input logic [3:0] asz,
                              input logic [2:0] asrc, input logic dv, input logic [2:0] dop,
                              input logic [3:0] dsz, input logic [2:0] dsrc, input logic ev,
                              input logic [3:0] fl, input logic [7:0] infl, input int ep,
                              input int err);
    vec_t v;
    v.av = av; v.aop = aop; v.asz = asz; v.asrc = asrc;
    v.dv = dv; v.dop = dop; v.dsz = dsz; v.dsrc = dsrc;
    v.ev = ev; v.fl = fl; v.infl = infl; v.ep = ep; v.err = err;
    return v;
  endfunction

  function automatic int nbeats(input int sz);
    return (sz <= 4) ? 1 : (1 << (sz - 4));
  endfunction

  function automatic bit d_ok(input int req, input int dop);
    case (req)
      0, 1:    return dop == 0;
      2, 3, 4: return dop == 1;
      5:       return dop == 2;
      default: return (dop == 4) || (dop == 5);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic av, input logic [2:0] aop, input logic [3:0] asz,
                        input logic [2:0] asrc, input logic dv, input logic [2:0] dop,
                        input logic [3:0] dsz, input logic [2:0] dsrc, input logic ev,
                        input logic ar, input logic dr, input logic er);
    tl.a_valid = av; tl.a_ready = ar; tl.a_opcode = aop; tl.a_size = asz; tl.a_source = asrc;
    tl.d_valid = dv; tl.d_ready = dr; tl.d_opcode = dop; tl.d_size = dsz; tl.d_source = dsrc;
    tl.e_valid = ev; tl.e_ready = er;
  endtask

  task automatic apply(input vec_t v, input int idx);
    set_in(v.av, v.aop, v.asz, v.asrc, v.dv, v.dop, v.dsz, v.dsrc, v.ev, 1'b1, 1'b1, 1'b1);
    #1;
    chk("a_first",  idx, 32'(tl.a_first),  32'(v.fl[3]));
    chk("a_last",   idx, 32'(tl.a_last),   32'(v.fl[2]));
    chk("d_first",  idx, 32'(tl.d_first),  32'(v.fl[1]));
    chk("d_last",   idx, 32'(tl.d_last),   32'(v.fl[0]));
    chk("src_busy", idx, 32'(tl.src_busy), 32'(mdl_infl[v.asrc]));
    @(posedge clock); #1;
    chk("inflight",  idx, 32'(tl.inflight),  32'(v.infl));
    chk("e_pending", idx, 32'(tl.e_pending), v.ep);
    chk("err_code",  idx, 32'(tl.err_code),  v.err);
    chk("err_valid", idx, 32'(tl.err_valid), 32'(v.err != 0));
    mdl_infl = v.infl;
  endtask

  // ---------------- random traffic + reference model ----------------
  task automatic run_random(input int n);
    int a_rem, d_rem, ep, err;
    int a_op, a_src, a_sz, d_op, d_src, d_sz, a_beats, d_beats;
    int m_op[8];
    int dops[6];
    logic [7:0] m_busy;
    logic av, ar, dv, dr, ev, er;
    bit af, al, df, dl, a_fire, d_fire, e_fire, trk, inc;
    logic [15:0] e;
    dops = '{0, 1, 2, 4, 5, 6};
    a_rem = 0; d_rem = 0; ep = 0; m_busy = '0;
    a_op = 0; a_src = 0; d_op = 0; d_src = 0; d_sz = 0;
    for (int i = 0; i < 8; i++) m_op[i] = 0;
    for (int cyc = 0; cyc < n; cyc++) begin
      if (a_rem == 0) begin
        a_op = $urandom_range(0, 7);
        if (m_busy != 8'hff && $urandom_range(0, 3) != 0) begin
          do a_src = $urandom_range(0, 7); while (m_busy[a_src]);
        end else a_src = $urandom_range(0, 7);
      end
      a_sz = $urandom_range(0, 7);  // ignored by the tracker mid-burst
      if (d_rem == 0) begin
        if (m_busy != 0 && $urandom_range(0, 9) < 8) begin
          do d_src = $urandom_range(0, 7); while (!m_busy[d_src]);
          case (m_op[d_src])
            0, 1:    d_op = 0;
            2, 3, 4: d_op = 1;
            5:       d_op = 2;
            default: d_op = 4 + $urandom_range(0, 1);
          endcase
          if ($urandom_range(0, 7) == 0) d_op = dops[$urandom_range(0, 5)];
        end else begin
          d_src = $urandom_range(0, 7);
          d_op  = dops[$urandom_range(0, 5)];
        end
        d_sz = $urandom_range(0, 7);
      end
      av = 1'($urandom_range(0, 1)); ar = ($urandom_range(0, 3) != 0);
      dv = 1'($urandom_range(0, 1)); dr = ($urandom_range(0, 3) != 0);
      ev = ($urandom_range(0, 2) == 0); er = ($urandom_range(0, 3) != 0);
      set_in(av, 3'(a_op), 4'(a_sz), 3'(a_src), dv, 3'(d_op), 4'(d_sz), 3'(d_src), ev, ar, dr, er);
      #1;
      a_beats = (a_op <= 3) ? nbeats(a_sz) : 1;
      d_beats = (d_op == 1 || d_op == 5) ? nbeats(d_sz) : 1;
      af = (a_rem == 0); al = af ? (a_beats == 1) : (a_rem == 1);
      df = (d_rem == 0); dl = df ? (d_beats == 1) : (d_rem == 1);
      chk("rnd.a_first",  cyc, 32'(tl.a_first),  32'(af));
      chk("rnd.a_last",   cyc, 32'(tl.a_last),   32'(al));
      chk("rnd.d_first",  cyc, 32'(tl.d_first),  32'(df));
      chk("rnd.d_last",   cyc, 32'(tl.d_last),   32'(dl));
      chk("rnd.src_busy", cyc, 32'(tl.src_busy), 32'(m_busy[a_src]));
      a_fire = av && ar; d_fire = dv && dr; e_fire = ev && er;
      trk = (d_op != 6);
      err = 0;
      if (e_fire && ep == 0) err = 4;
      if (d_fire && df && trk && m_busy[d_src] && !d_ok(m_op[d_src], d_op)) err = 3;
      if (d_fire && df && trk && !m_busy[d_src]) err = 2;
      if (a_fire && af && m_busy[a_src] && !(d_fire && dl && trk && d_src == a_src)) err = 1;
      if (d_fire && dl && trk) m_busy[d_src] = 1'b0;
      if (a_fire && af) begin m_busy[a_src] = 1'b1; m_op[a_src] = a_op; end
      if (a_fire) a_rem = af ? a_beats - 1 : a_rem - 1;
      if (d_fire) d_rem = df ? d_beats - 1 : d_rem - 1;
      inc = d_fire && dl && (d_op == 4 || d_op == 5);
      if (inc && !e_fire) ep++;
      else if (e_fire && !inc && ep > 0) ep--;
      exp_q.push_back({4'(ep), (err != 0), 3'(err), m_busy});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      chk("rnd.inflight",  cyc, 32'(tl.inflight),  32'(e[7:0]));
      chk("rnd.err_code",  cyc, 32'(tl.err_code),  32'(e[10:8]));
      chk("rnd.err_valid", cyc, 32'(tl.err_valid), 32'(e[11]));
      chk("rnd.e_pending", cyc, 32'(tl.e_pending), 32'(e[15:12]));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // idle channels: A Get size 0 and D AccessAck size 0 are single beats
    vecs.push_back(mk(1, Get, 6, 2,          0, AccessAck, 0, 0,     0, 4'b1111, 8'h04, 0, 0));
    vecs.push_back(mk(0, Get, 0, 0,          1, AccessAckData, 6, 2, 0, 4'b1110, 8'h04, 0, 0));
    vecs.push_back(mk(0, Get, 0, 0,          1, AccessAckData, 6, 2, 0, 4'b1100, 8'h04, 0, 0));
    vecs.push_back(mk(0, Get, 0, 0,          1, AccessAckData, 6, 2, 0, 4'b1100, 8'h04, 0, 0));
    vecs.push_back(mk(0, Get, 0, 0,          1, AccessAckData, 6, 2, 0, 4'b1101, 8'h00, 0, 0));
    vecs.push_back(mk(1, PutFullData, 5, 0,  0, AccessAck, 0, 0,     0, 4'b1011, 8'h01, 0, 0));
    vecs.push_back(mk(1, PutFullData, 9, 0,  0, AccessAck, 0, 0,     0, 4'b0111, 8'h01, 0, 0));
    vecs.push_back(mk(0, Get, 0, 0,          1, AccessAck, 5, 0,     0, 4'b1111, 8'h00, 0, 0));
    vecs.push_back(mk(1, PutFullData, 3, 0,  0, AccessAck, 0, 0,     0, 4'b1111, 8'h01, 0, 0));
    vecs.push_back(mk(0, Get, 0, 0,          1, AccessAck, 3, 0,     0, 4'b1111, 8'h00, 0, 0));
    vecs.push_back(mk(1, AcquireBlock, 6, 1, 0, AccessAck, 0, 0,     0, 4'b1111, 8'h02, 0, 0));
    vecs.push_back(mk(0, Get, 0, 0,          1, GrantData, 6, 1,     0, 4'b1110, 8'h02, 0, 0));
    vecs.push_back(mk(0, Get, 0, 0,          1, GrantData, 6, 1,     0, 4'b1100, 8'h02, 0, 0));
    vecs.push_back(mk(0, Get, 0, 0,          1, GrantData, 6, 1,     0, 4'b1100, 8'h02, 0, 0));
    vecs.push_back(mk(0, Get, 0, 0,          1, GrantData, 6, 1,     0, 4'b1101, 8'h00, 1, 0));
    vecs.push_back(mk(0, Get, 0, 0,          0, AccessAck, 0, 0,     1, 4'b1111, 8'h00, 0, 0));
    vecs.push_back(mk(0, Get, 0, 0,          0, AccessAck, 0, 0,     1, 4'b1111, 8'h00, 0, 4));
    vecs.push_back(mk(0, Get, 0, 0,          0, AccessAck, 0, 0,     0, 4'b1111, 8'h00, 0, 0));
    vecs.push_back(mk(1, Get, 6, 3,          0, AccessAck, 0, 0,     0, 4'b1111, 8'h08, 0, 0));
    vecs.push_back(mk(1, Get, 6, 3,          0, AccessAck, 0, 0,     0, 4'b1111, 8'h08, 0, 1));
    vecs.push_back(mk(0, Get, 0, 0,          1, AccessAckData, 4, 5, 0, 4'b1111, 8'h08, 0, 2));
    vecs.push_back(mk(0, Get, 0, 0,          1, AccessAck, 0, 3,     0, 4'b1111, 8'h00, 0, 3));
    vecs.push_back(mk(1, Get, 0, 4,          0, AccessAck, 0, 0,     0, 4'b1111, 8'h10, 0, 0));
    vecs.push_back(mk(1, Get, 0, 4,          1, AccessAckData, 0, 4, 0, 4'b1111, 8'h10, 0, 0));
    vecs.push_back(mk(0, Get, 0, 0,          1, AccessAckData, 0, 4, 0, 4'b1111, 8'h00, 0, 0));
    vecs.push_back(mk(1, Get, 0, 6,          0, AccessAck, 0, 0,     0, 4'b1111, 8'h40, 0, 0));
    vecs.push_back(mk(1, Get, 0, 6,          1, AccessAckData, 0, 5, 0, 4'b1111, 8'h40, 0, 1));
    vecs.push_back(mk(0, Get, 0, 0,          1, AccessAckData, 0, 6, 0, 4'b1111, 8'h00, 0, 0));

    // reset state
    set_in(0, 3'd0, 4'd0, 3'd0, 0, 3'd0, 4'd0, 3'd0, 0, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.inflight",  0, 32'(tl.inflight),  0);
    chk("rst.e_pending", 0, 32'(tl.e_pending), 0);
    chk("rst.err_valid", 0, 32'(tl.err_valid), 0);
    chk("rst.err_code",  0, 32'(tl.err_code),  0);
    chk("rst.a_first",   0, 32'(tl.a_first),   1);
    chk("rst.d_first",   0, 32'(tl.d_first),   1);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // reset in the middle of a 4-beat D burst, with a GrantAck owed
    apply(mk(1, AcquireBlock, 0, 1, 0, AccessAck, 0, 0,     0, 4'b1111, 8'h02, 0, 0), 100);
    apply(mk(0, Get, 0, 0,          1, Grant, 0, 1,         0, 4'b1111, 8'h00, 1, 0), 101);
    apply(mk(1, Get, 6, 2,          0, AccessAck, 0, 0,     0, 4'b1111, 8'h04, 1, 0), 102);
    apply(mk(0, Get, 0, 0,          1, AccessAckData, 6, 2, 0, 4'b1110, 8'h04, 1, 0), 103);
    apply(mk(0, Get, 0, 0,          1, AccessAckData, 6, 2, 0, 4'b1100, 8'h04, 1, 0), 104);
    set_in(0, Get, 4'd0, 3'd2, 1, AccessAckData, 4'd6, 3'd2, 0, 1'b1, 1'b1, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst.inflight",  0, 32'(tl.inflight),  0);
    chk("mid_rst.e_pending", 0, 32'(tl.e_pending), 0);
    chk("mid_rst.err_valid", 0, 32'(tl.err_valid), 0);
    chk("mid_rst.err_code",  0, 32'(tl.err_code),  0);
    chk("mid_rst.a_first",   0, 32'(tl.a_first),   1);
    chk("mid_rst.d_first",   0, 32'(tl.d_first),   1);
    chk("mid_rst.src_busy",  0, 32'(tl.src_busy),  0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("post_rst.d_first", 0, 32'(tl.d_first), 1);
    chk("post_rst.d_last",  0, 32'(tl.d_last),  0);
    @(posedge clock); #1;
    chk("post_rst.err_code",  0, 32'(tl.err_code),  2);
    chk("post_rst.err_valid", 0, 32'(tl.err_valid), 1);
    chk("post_rst.inflight",  0, 32'(tl.inflight),  0);

    // clean slate for random traffic
    set_in(0, 3'd0, 4'd0, 3'd0, 0, 3'd0, 4'd0, 3'd0, 0, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    run_random(3000);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
